// File: rtl/spu_rf_fwd.sv
// spu_rf_fwd: register-fetch / operand-forward stage feeding the SPU fixed-point execute pipes.
// Build option SPU_FWD_EN: defined = fw/wb bypass; undefined = RF-only reads, stall on any pending write.
module spu_rf_fwd #(
    parameter int NUM_REGS = 128,
    parameter int DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [0:10]             op_in,
    input  logic [2:0]              format_in,
    input  logic [6:0]              rt_addr_in,
    input  logic [6:0]              ra_addr,
    input  logic [6:0]              rb_addr,
    input  logic [0:17]             imm_in,
    input  logic                    reg_write_in,
    input  logic                    flush,
    input  logic [DEPTH-1:0][127:0] fw_data,
    input  logic [DEPTH-1:0][6:0]   fw_addr,
    input  logic [DEPTH-1:0]        fw_we,
    input  logic [DEPTH-1:0]        fw_ready,
    input  logic [127:0]            wb_data,
    input  logic [6:0]              wb_addr,
    input  logic                    wb_we,
    output logic [0:10]             op,
    output logic [2:0]              format,
    output logic [6:0]              rt_addr,
    output logic [127:0]            ra,
    output logic [127:0]            rb,
    output logic [0:17]             imm,
    output logic                    reg_write,
    output logic                    out_valid
);

    // Handshake: an instruction is taken on a posedge with in_valid && in_ready; while in_ready
    // is low upstream holds every input field. flush consumes and discards the instruction.
    logic [127:0] rf [NUM_REGS];
    logic [127:0] ra_val, rb_val;
    logic         ra_stall, rb_stall;
    logic         hazard;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        end else if (wb_we) begin
            rf[wb_addr] <= wb_data;
        end
    end

`ifdef SPU_FWD_EN
    // Returns {stall, value}: oldest stage first so the youngest match overwrites it.
    function automatic logic [128:0] resolve(input logic [6:0] src, input logic [127:0] rf_val);
        logic [127:0] val;
        logic         stall;
        val   = rf_val;
        stall = 1'b0;
        if (wb_we && (wb_addr == src)) val = wb_data;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (fw_we[i] && (fw_addr[i] == src)) begin
                val   = fw_data[i];
                stall = !fw_ready[i];
            end
        end
        return {stall, val};
    endfunction

    always_comb begin
        {ra_stall, ra_val} = resolve(ra_addr, rf[ra_addr]);
        {rb_stall, rb_val} = resolve(rb_addr, rf[rb_addr]);
    end
`else
    // Without bypass, any in-flight write to a source must land in the RF before the read.
    function automatic logic pending(input logic [6:0] src);
        logic hit;
        hit = wb_we && (wb_addr == src);
        for (int i = 0; i < DEPTH; i++) begin
            if (fw_we[i] && (fw_addr[i] == src)) hit = 1'b1;
        end
        return hit;
    endfunction

    logic unused_fw;
    assign unused_fw = ^{fw_data, fw_ready};

    always_comb begin
        ra_val   = rf[ra_addr];
        rb_val   = rf[rb_addr];
        ra_stall = pending(ra_addr);
        rb_stall = pending(rb_addr);
    end
`endif

    assign hazard   = in_valid && (ra_stall || rb_stall);
    assign in_ready = reset || flush || !hazard;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op        <= '0;
            format    <= '0;
            rt_addr   <= '0;
            ra        <= '0;
            rb        <= '0;
            imm       <= '0;
            reg_write <= 1'b0;
            out_valid <= 1'b0;
        end else if (in_valid && !hazard && !flush) begin
            op        <= op_in;
            format    <= format_in;
            rt_addr   <= rt_addr_in;
            ra        <= ra_val;
            rb        <= rb_val;
            imm       <= imm_in;
            reg_write <= reg_write_in;
            out_valid <= 1'b1;
        end else begin
            // flush, hazard and idle cycles all issue a nop bubble
            op        <= '0;
            format    <= '0;
            rt_addr   <= '0;
            ra        <= '0;
            rb        <= '0;
            imm       <= '0;
            reg_write <= 1'b0;
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spu_rf_fwd.sv
// Directed self-checking bench for spu_rf_fwd; covers both SPU_FWD_EN builds.
module tb_spu_rf_fwd;

    localparam int DEPTH = 4;
    localparam logic [127:0] ONES = {32{4'h1}};
    localparam logic [127:0] AAAA = {32{4'hA}};

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    in_valid, in_ready;
    logic [0:10]             op_in;
    logic [2:0]              format_in;
    logic [6:0]              rt_addr_in, ra_addr, rb_addr;
    logic [0:17]             imm_in;
    logic                    reg_write_in, flush;
    logic [DEPTH-1:0][127:0] fw_data;
    logic [DEPTH-1:0][6:0]   fw_addr;
    logic [DEPTH-1:0]        fw_we, fw_ready;
    logic [127:0]            wb_data;
    logic [6:0]              wb_addr;
    logic                    wb_we;
    logic [0:10]             op;
    logic [2:0]              format;
    logic [6:0]              rt_addr;
    logic [127:0]            ra, rb;
    logic [0:17]             imm;
    logic                    reg_write, out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    spu_rf_fwd #(.NUM_REGS(128), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op_in(op_in), .format_in(format_in), .rt_addr_in(rt_addr_in),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .imm_in(imm_in),
        .reg_write_in(reg_write_in), .flush(flush),
        .fw_data(fw_data), .fw_addr(fw_addr), .fw_we(fw_we), .fw_ready(fw_ready),
        .wb_data(wb_data), .wb_addr(wb_addr), .wb_we(wb_we),
        .op(op), .format(format), .rt_addr(rt_addr), .ra(ra), .rb(rb),
        .imm(imm), .reg_write(reg_write), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        in_valid = 1'b0; flush = 1'b0;
        op_in = '0; format_in = '0; rt_addr_in = '0; ra_addr = '0; rb_addr = '0;
        imm_in = '0; reg_write_in = 1'b0;
        fw_data = '0; fw_addr = '0; fw_we = '0; fw_ready = '0;
        wb_data = '0; wb_addr = '0; wb_we = 1'b0;
    endtask

    task automatic drive_instr(input logic [6:0] a, input logic [6:0] b, input logic [6:0] rt,
                               input logic [10:0] opv, input logic [17:0] immv);
        in_valid = 1'b1; ra_addr = a; rb_addr = b; rt_addr_in = rt;
        op_in = opv; format_in = 3'd2; imm_in = immv; reg_write_in = 1'b1;
    endtask

    task automatic wb_write(input logic [6:0] addr, input logic [127:0] data);
        @(negedge clk);
        drive_idle();
        wb_we = 1'b1; wb_addr = addr; wb_data = data;
        @(posedge clk);
        @(negedge clk);
        drive_idle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        drive_instr(7'd3, 7'd4, 7'd1, 11'h7ff, 18'h3ffff);
        fw_we[0] = 1'b1; fw_addr[0] = 7'd3;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, op, format, rt_addr, imm, reg_write, ra, rb} !== '0) begin
            n_fail++; $display("FAIL reset_bundle: out_valid=%b op=%h ra=%h expected all zero", out_valid, op, ra);
        end
        @(negedge clk);
        reset = 1'b0;
        drive_idle();
        drive_instr(7'd20, 7'd21, 7'd2, 11'h001, 18'h00001);
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, ra, rb} !== {1'b1, 256'h0}) begin
            n_fail++; $display("FAIL reset_rf_clear: out_valid=%b ra=%h rb=%h expected 1/0/0", out_valid, ra, rb);
        end
    endtask

    task automatic test_rf_read();
        wb_write(7'd5, ONES);
        drive_instr(7'd5, 7'd6, 7'd10, 11'h123, 18'h2abcd);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rf_read_ready: got %b expected 1", in_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (ra !== ONES || rb !== 128'h0) begin
            n_fail++; $display("FAIL rf_read_operands: ra=%h rb=%h expected %h / 0", ra, rb, ONES);
        end
        n_checks++;
        if ({out_valid, op, format, rt_addr, imm, reg_write} !== {1'b1, 11'h123, 3'd2, 7'd10, 18'h2abcd, 1'b1}) begin
            n_fail++; $display("FAIL rf_read_bundle: v=%b op=%h fmt=%0d rt=%0d imm=%h rw=%b", out_valid, op, format, rt_addr, imm, reg_write);
        end
        @(negedge clk);
        drive_idle();
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, op, rt_addr, reg_write, ra} !== '0) begin
            n_fail++; $display("FAIL idle_nop: v=%b op=%h ra=%h expected zero", out_valid, op, ra);
        end
    endtask

    task automatic test_writethrough();
        @(negedge clk);
        drive_idle();
        wb_we = 1'b1; wb_addr = 7'd7; wb_data = AAAA;
        drive_instr(7'd7, 7'd5, 7'd11, 11'h055, 18'h00123);
`ifndef SPU_FWD_EN
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL wb_stall_ready: got %b expected 0", in_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL wb_stall_nop: out_valid=%b expected 0", out_valid);
        end
        @(negedge clk);
        wb_we = 1'b0;
`endif
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL wb_accept_ready: got %b expected 1", in_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, ra, rb} !== {1'b1, AAAA, ONES}) begin
            n_fail++; $display("FAIL wb_writethrough: v=%b ra=%h rb=%h expected 1/%h/%h", out_valid, ra, rb, AAAA, ONES);
        end
    endtask

    task automatic test_youngest();
        wb_write(7'd9, 128'h55);
        drive_instr(7'd1, 7'd9, 7'd12, 11'h0aa, 18'h00002);
        fw_we[0] = 1'b1; fw_addr[0] = 7'd9; fw_data[0] = 128'h2;
        fw_we[2] = 1'b1; fw_addr[2] = 7'd9; fw_data[2] = 128'h3;
        fw_ready = 4'b1011;
`ifdef SPU_FWD_EN
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL youngest_ready: got %b expected 1 (older stage not ready is ignored)", in_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, rb} !== {1'b1, 128'h2}) begin
            n_fail++; $display("FAIL youngest_wins: v=%b rb=%h expected 1/2", out_valid, rb);
        end
`else
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL nofwd_two_stage_ready: got %b expected 0", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        fw_we[0] = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL nofwd_older_stage_stall: in_ready=%b out_valid=%b expected 0/0", in_ready, out_valid);
        end
        @(posedge clk);
        @(negedge clk);
        fw_we[2] = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, rb} !== {1'b1, 128'h55}) begin
            n_fail++; $display("FAIL nofwd_rf_after_stall: v=%b rb=%h expected 1/55", out_valid, rb);
        end
`endif
    endtask

    task automatic test_stall_release();
        wb_write(7'd12, 128'hc0ffee);
        drive_instr(7'd1, 7'd12, 7'd13, 11'h0f0, 18'h00abc);
        fw_we[3] = 1'b1; fw_addr[3] = 7'd12; fw_data[3] = 128'hdead; fw_ready[3] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++; $display("FAIL stall_ready cycle %0d: got %b expected 0", c, in_ready);
            end
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid, rb, op} !== '0) begin
                n_fail++; $display("FAIL stall_nop cycle %0d: v=%b rb=%h op=%h expected zero", c, out_valid, rb, op);
            end
            @(negedge clk);
        end
        fw_we[3] = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, rb, op, rt_addr} !== {1'b1, 128'hc0ffee, 11'h0f0, 7'd13}) begin
            n_fail++; $display("FAIL stall_release_rf: v=%b rb=%h op=%h rt=%0d expected 1/c0ffee/0f0/13", out_valid, rb, op, rt_addr);
        end
`ifdef SPU_FWD_EN
        @(negedge clk);
        drive_idle();
        drive_instr(7'd3, 7'd1, 7'd14, 11'h00f, 18'h0);
        fw_we[1] = 1'b1; fw_addr[1] = 7'd3; fw_data[1] = 128'h77; fw_ready[1] = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL fwd_not_ready: got %b expected 0", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        fw_ready[1] = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, ra} !== {1'b1, 128'h77}) begin
            n_fail++; $display("FAIL fwd_ready_release: v=%b ra=%h expected 1/77", out_valid, ra);
        end
`endif
    endtask

    task automatic test_flush();
        @(negedge clk);
        drive_idle();
        drive_instr(7'd4, 7'd5, 7'd15, 11'h3c3, 18'h1);
        fw_we[0] = 1'b1; fw_addr[0] = 7'd4; fw_ready[0] = 1'b0;
        flush = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_ready: got %b expected 1", in_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, op, rt_addr, reg_write} !== '0) begin
            n_fail++; $display("FAIL flush_hazard_nop: v=%b op=%h expected zero", out_valid, op);
        end
        @(negedge clk);
        drive_idle();
        drive_instr(7'd5, 7'd5, 7'd16, 11'h111, 18'h2);
        flush = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, ra, op} !== '0) begin
            n_fail++; $display("FAIL flush_clean_nop: v=%b ra=%h op=%h expected zero", out_valid, ra, op);
        end
        @(negedge clk);
        drive_idle();
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_dropped: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] vals [3];
        vals[0] = 128'h1000; vals[1] = 128'h2001; vals[2] = 128'h3002;
        for (int i = 0; i < 3; i++) wb_write(7'(20 + i), vals[i]);
        for (int i = 0; i < 3; i++) begin
            drive_instr(7'(20 + i), 7'(22 - i), 7'(40 + i), 11'(i + 1), 18'(i * 3));
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid, ra, rb, op, rt_addr, imm} !==
                {1'b1, vals[i], vals[2 - i], 11'(i + 1), 7'(40 + i), 18'(i * 3)}) begin
                n_fail++; $display("FAIL b2b[%0d]: v=%b ra=%h rb=%h op=%h rt=%0d imm=%h", i, out_valid, ra, rb, op, rt_addr, imm);
            end
            @(negedge clk);
        end
        drive_idle();
    endtask

    task automatic test_async_reset();
        drive_instr(7'd5, 7'd20, 7'd1, 11'h222, 18'h3);
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, op, ra, rb} !== '0) begin
            n_fail++; $display("FAIL async_reset_clear: v=%b op=%h ra=%h expected zero", out_valid, op, ra);
        end
        @(negedge clk);
        reset = 1'b0;
        drive_instr(7'd5, 7'd20, 7'd1, 11'h222, 18'h3);
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, ra, rb} !== {1'b1, 256'h0}) begin
            n_fail++; $display("FAIL async_reset_rf: v=%b ra=%h rb=%h expected 1/0/0", out_valid, ra, rb);
        end
        @(negedge clk);
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_rf_read();
        test_writethrough();
        test_youngest();
        test_stall_release();
        test_flush();
        test_back_to_back();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spu_rf_fwd.md
Name: spu_rf_fwd

Overview:
Register-fetch/forward (RF/FWD) stage that sits directly upstream of the fixed-point execution pipes.
- Holds the 128 x 128-bit SPU register file.
- Reads the two source operands and resolves them against in-flight results from the execution pipe's delay stages and the writeback port.
- Delivers a registered op/format/rt_addr/ra/rb/imm/reg_write bundle one cycle after acceptance.
- Inserts nop bubbles on unresolved read-after-write (RAW) hazards and on branch flush.

Parameters:
NUM_REGS, 128, number of architectural registers (address width fixed at 7).
DEPTH, 4, number of execution delay stages presented for forwarding.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  decoded instruction present
in_ready  output  1  stage accepts instruction this cycle
op_in  input  11  decoded opcode [0:10]
format_in  input  3  instruction format
rt_addr_in  input  7  destination register
ra_addr  input  7  source A register
rb_addr  input  7  source B register
imm_in  input  18  immediate [0:17]
reg_write_in  input  1  instruction writes rt
flush  input  1  branch taken; kill the instruction in this stage
fw_data  input  DEPTH x 128  per-stage result, index 0 youngest
fw_addr  input  DEPTH x 7  per-stage destination
fw_we  input  DEPTH  per-stage write enable
fw_ready  input  DEPTH  per-stage result already computed
wb_data  input  128  writeback value
wb_addr  input  7  writeback register
wb_we  input  1  writeback enable
op, format, rt_addr, ra, rb, imm, reg_write  output  11/3/7/128/128/18/1  registered execute bundle
out_valid  output  1  bundle holds a real instruction

Behaviour:
Reset:
- Asynchronous, active-high.
- All outputs go to 0; out_valid=0; every register-file entry cleared to 0.
- in_ready is combinational and evaluates to 1 while reset is asserted.
- Any instruction in flight is dropped.

Register file:
- On a posedge with wb_we=1, RF[wb_addr] <= wb_data.
- Reads are combinational.

Operand resolution (per source, ra and rb independently), priority order:
1. Youngest fw stage i (lowest index) with fw_we[i]=1 and fw_addr[i]==src.
2. Else the writeback port when wb_we=1 and wb_addr==src (same-cycle write-through).
3. Else RF[src].
- Only the youngest match counts; older matching stages are ignored.

Hazard:
- hazard = in_valid and, for either source, the selected youngest fw match has fw_ready=0.
- in_ready = !hazard.

Per-cycle update, in priority order:
- flush=1: load a nop bundle (op=0, format=0, rt_addr=0, reg_write=0, ra=rb=imm=0, out_valid=0). The input instruction is consumed (in_ready=1) and discarded.
- hazard: load a nop bundle. in_ready=0; upstream holds its inputs.
- in_valid && !hazard: capture op_in, format_in, rt_addr_in, imm_in, reg_write_in and the resolved ra/rb. out_valid=1.
- !in_valid: load a nop bundle.

Latency: 1 cycle from acceptance to bundle. No backpressure from downstream.

Simultaneous events:
- flush wins over hazard.
- A writeback to the same register in the same cycle as a read returns wb_data.
- fw_data of a stage with fw_we=0 is never used.

Optional Feature:
SPU_FWD_EN
- Defined: full forwarding as above.
- Undefined: no fw/wb bypass; operands come only from RF.
  - hazard = in_valid and any source matches any stage with fw_we=1, or matches wb_addr with wb_we=1.
  - fw_data and wb-bypass paths are not built.

Test Plan:
- Reset, then write RF[5]=0x1111...1 via wb. Issue ra_addr=5 one cycle later → ra=0x1111...1, out_valid=1, 1-cycle latency.
- Same cycle: wb_addr=7 with wb_data=0xAAAA...A, and ra_addr=7 issued → ra=0xAAAA...A (write-through).
- fw stage0 and stage2 both target r9 with values 0x2 and 0x3, all ready; rb_addr=9 → rb=0x2 (youngest wins).
- fw stage1 targets r3 with fw_ready=0; ra_addr=3 → in_ready=0 and nop bundle while not ready. Set fw_ready[1]=1 → instruction accepted next edge with the forwarded value.
- Hazard pending and flush=1 in the same cycle → nop bundle, in_ready=1, instruction dropped.
- Without SPU_FWD_EN: rb_addr matches fw_addr[3] with fw_we[3]=1 → stall until the entry clears, then the RF value is used.
